// File: rtl/status_reg_pkg.sv
// Shared constants and types for the 6502 processor status register (P).
// Flag bit positions, status-operation codes and the reset value of P.
package status_reg_pkg;

    localparam int C_FLAG_SHFT_C = 0;
    localparam int C_FLAG_SHFT_Z = 1;
    localparam int C_FLAG_SHFT_I = 2;
    localparam int C_FLAG_SHFT_D = 3;
    localparam int C_FLAG_SHFT_B = 4;
    localparam int C_FLAG_SHFT_U = 5;
    localparam int C_FLAG_SHFT_V = 6;
    localparam int C_FLAG_SHFT_N = 7;

    typedef enum logic [3:0] {
        C_SR_CTRL_NOP = 4'd0,
        C_SR_CTRL_ALU = 4'd1,
        C_SR_CTRL_PLP = 4'd2,
        C_SR_CTRL_RTI = 4'd3,
        C_SR_CTRL_CLC = 4'd4,
        C_SR_CTRL_SEC = 4'd5,
        C_SR_CTRL_CLI = 4'd6,
        C_SR_CTRL_SEI = 4'd7,
        C_SR_CTRL_CLV = 4'd8,
        C_SR_CTRL_CLD = 4'd9,
        C_SR_CTRL_SED = 4'd10,
        C_SR_CTRL_INT = 4'd11
    } sr_ctrl_e;

    localparam logic [7:0] C_SR_RST_P = 8'h34;

    // Only N, V, Z and C may be written by the ALU path.
    localparam logic [7:0] C_SR_ALU_MASK = 8'hC3;

    // Bits 5 and 4 have no storage of their own; they always read back as 1.
    localparam logic [7:0] C_SR_FIXED_ONES = 8'h30;

    function automatic logic [7:0] sr_fix(input logic [7:0] p);
        return p | C_SR_FIXED_ONES;
    endfunction

endpackage

// File: rtl/status_reg_if.sv
// Control/data bundle between the sequencer/ALU side and the status register.
// master = sequencer side, slave = status register.
interface status_reg_if;
    import status_reg_pkg::*;

    logic [3:0] ctrl;
    logic [7:0] alu_flag;
    logic [7:0] upd_mask;
    logic [7:0] db_in;
    logic       sync;
    logic       brk_src;
    logic [7:0] flag;
    logic [7:0] push_out;
    logic       irq_mask;

    modport master (
        output ctrl, alu_flag, upd_mask, db_in, sync, brk_src,
        input  flag, push_out, irq_mask
    );

    modport slave (
        input  ctrl, alu_flag, upd_mask, db_in, sync, brk_src,
        output flag, push_out, irq_mask
    );

endinterface

// File: rtl/status_reg.sv
// 6502 processor status register: ALU flag update, flag set/clear, PLP/RTI load,
// interrupt-entry I set, stack push value and the one-instruction-delayed IRQ mask.
module status_reg
    import status_reg_pkg::*;
#(
    parameter logic [7:0] RST_P = C_SR_RST_P
) (
    input  logic          clk,
    input  logic          rst,
    status_reg_if.slave   bus
);

    logic [7:0] p_q;
    logic [7:0] p_nxt;
    logic       irq_mask_q;
    logic       irq_mask_nxt;
    logic [7:0] alu_we;

    assign alu_we = bus.upd_mask & C_SR_ALU_MASK;

    always_comb begin
        p_nxt        = p_q;
        irq_mask_nxt = irq_mask_q;

        // IRQ recognition sees I as it stood before this cycle's update.
        if (bus.sync) begin
            irq_mask_nxt = p_q[C_FLAG_SHFT_I];
        end

        case (sr_ctrl_e'(bus.ctrl))
            C_SR_CTRL_ALU: p_nxt = (p_q & ~alu_we) | (bus.alu_flag & alu_we);
            C_SR_CTRL_PLP: p_nxt = bus.db_in;
            C_SR_CTRL_RTI: begin
                p_nxt        = bus.db_in;
                irq_mask_nxt = bus.db_in[C_FLAG_SHFT_I];
            end
            C_SR_CTRL_CLC: p_nxt[C_FLAG_SHFT_C] = 1'b0;
            C_SR_CTRL_SEC: p_nxt[C_FLAG_SHFT_C] = 1'b1;
            C_SR_CTRL_CLI: p_nxt[C_FLAG_SHFT_I] = 1'b0;
            C_SR_CTRL_SEI: p_nxt[C_FLAG_SHFT_I] = 1'b1;
            C_SR_CTRL_CLV: p_nxt[C_FLAG_SHFT_V] = 1'b0;
            C_SR_CTRL_CLD: p_nxt[C_FLAG_SHFT_D] = 1'b0;
            C_SR_CTRL_SED: p_nxt[C_FLAG_SHFT_D] = 1'b1;
            C_SR_CTRL_INT: begin
                p_nxt[C_FLAG_SHFT_I] = 1'b1;
                irq_mask_nxt         = 1'b1;
            end
            default: p_nxt = p_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q        <= sr_fix(RST_P);
            irq_mask_q <= 1'b1;
        end else begin
            p_q        <= sr_fix(p_nxt);
            irq_mask_q <= irq_mask_nxt;
        end
    end

    assign bus.flag     = p_q;
    assign bus.irq_mask = irq_mask_q;
    assign bus.push_out = {p_q[C_FLAG_SHFT_N], p_q[C_FLAG_SHFT_V], 1'b1, bus.brk_src,
                           p_q[C_FLAG_SHFT_D:C_FLAG_SHFT_C]};

endmodule
